// File: rtl/ssd1306_pkg.sv
// ---------------------------------------------------------------------------
// ssd1306_pkg
// Shared definitions for the SSD1306 microcode sequencer. The microcode
// assembler and the .mif generator use the same constants.
//   - opcode_e     : microcode opcodes (bits [9:8] of a word)
//   - seq_state_e  : sequencer FSM states
//   - word field bit positions and widths
// ---------------------------------------------------------------------------
package ssd1306_pkg;

    localparam int WORD_WIDTH    = 10;
    localparam int OPCODE_MSB    = 9;
    localparam int OPCODE_LSB    = 8;
    localparam int PAYLOAD_MSB   = 7;
    localparam int PAYLOAD_LSB   = 0;
    localparam int PAYLOAD_WIDTH = PAYLOAD_MSB - PAYLOAD_LSB + 1;

    typedef enum logic [1:0] {
        OP_CMD   = 2'b00,
        OP_DATA  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DELAY,
        ST_DONE
    } seq_state_e;

    function automatic opcode_e word_opcode(input logic [WORD_WIDTH-1:0] word);
        return opcode_e'(word[OPCODE_MSB:OPCODE_LSB]);
    endfunction

    function automatic logic [PAYLOAD_WIDTH-1:0] word_payload(input logic [WORD_WIDTH-1:0] word);
        return word[PAYLOAD_MSB:PAYLOAD_LSB];
    endfunction

endpackage

// File: rtl/ssd1306_delay_timer.sv
// ---------------------------------------------------------------------------
// ssd1306_delay_timer
// Load/count/expire down-counter used to execute DELAY microcode words.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : load count with load_value (takes priority over counting)
//   load_value  : initial count
//   count_en    : decrement by one per cycle while nonzero
//   expired     : count is zero (combinational)
// ---------------------------------------------------------------------------
module ssd1306_delay_timer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   count_en,
    output logic                   expired
);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ssd1306_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// ssd1306_microcode_sequencer
// Walks the SSD1306 microcode ROM from address 0, sending CMD/DATA bytes to
// the SPI transmitter over valid/ready and executing DELAY words locally.
// Stops on an END word or when the address leaves the ROM (error set).
//   clk, rst             : clock, asynchronous active-high reset
//   start                : run request, sampled only in IDLE
//   rom_address          : ROM read address (ROM answers combinationally)
//   rom_data             : ROM word at rom_address
//   rom_address_overflow : ROM flag, rom_address >= ROM_SIZE
//   tx_data, tx_dc       : byte and D/C# line (0 = command, 1 = data)
//   tx_valid, tx_ready   : transmit handshake
//   busy                 : run in progress (through the DONE cycle)
//   done                 : one-cycle completion pulse
//   error                : sticky overflow flag, cleared by the next start
// ---------------------------------------------------------------------------
module ssd1306_microcode_sequencer
    import ssd1306_pkg::*;
#(
    parameter  int ROM_SIZE     = 40,
    parameter  int DATA_WIDTH   = 10,
    parameter  int DELAY_SHIFT  = 8,
    localparam int ADDRESS_BITS = $clog2(ROM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDRESS_BITS-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0]   rom_data,
    input  logic                    rom_address_overflow,
    output logic [7:0]              tx_data,
    output logic                    tx_dc,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int COUNT_WIDTH = PAYLOAD_WIDTH + DELAY_SHIFT;

    seq_state_e               state;
    opcode_e                  opcode;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [ADDRESS_BITS:0]    address_inc;
    logic                     address_wrapped;
    logic                     fetch_overflow;
    logic                     timer_load;
    logic                     timer_expired;
    logic [COUNT_WIDTH-1:0]   timer_load_value;

    assign opcode  = word_opcode(rom_data[WORD_WIDTH-1:0]);
    assign payload = word_payload(rom_data[WORD_WIDTH-1:0]);

    // One extra bit catches the carry out of the address counter; with a
    // power-of-two ROM the address would otherwise wrap silently to 0.
    assign address_inc    = {1'b0, rom_address} + (ADDRESS_BITS+1)'(1);
    assign fetch_overflow = rom_address_overflow || address_wrapped;

    assign timer_load       = (state == ST_FETCH) && !fetch_overflow && (opcode == OP_DELAY);
    assign timer_load_value = COUNT_WIDTH'(payload) << DELAY_SHIFT;

    ssd1306_delay_timer #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_delay_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count_en   (state == ST_DELAY),
        .expired    (timer_expired)
    );

    // NOTE: all state and outputs are registered here with non-blocking
    // assignments, so every branch sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            rom_address     <= '0;
            address_wrapped <= 1'b0;
            tx_data         <= '0;
            tx_dc           <= 1'b0;
            tx_valid        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        rom_address     <= '0;
                        address_wrapped <= 1'b0;
                        error           <= 1'b0;
                        busy            <= 1'b1;
                        state           <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (fetch_overflow) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        unique case (opcode)
                            OP_CMD, OP_DATA: begin
                                tx_data  <= payload;
                                tx_dc    <= (opcode == OP_DATA);
                                tx_valid <= 1'b1;
                                state    <= ST_SEND;
                            end
                            OP_DELAY: state <= ST_DELAY;
                            OP_END: begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end

                ST_SEND: begin
                    // tx_valid stays up until accepted; only rst withdraws it.
                    if (tx_ready) begin
                        tx_valid        <= 1'b0;
                        rom_address     <= address_inc[ADDRESS_BITS-1:0];
                        address_wrapped <= address_wrapped | address_inc[ADDRESS_BITS];
                        state           <= ST_FETCH;
                    end
                end

                ST_DELAY: begin
                    if (timer_expired) begin
                        rom_address     <= address_inc[ADDRESS_BITS-1:0];
                        address_wrapped <= address_wrapped | address_inc[ADDRESS_BITS];
                        state           <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ssd1306_microcode_sequencer
// Self-checking bench. Expected byte streams, run lengths and error flags are
// derived from the ROM contents by a word-cost model of the sequencer.
// ---------------------------------------------------------------------------
module tb_ssd1306_microcode_sequencer;

    localparam int ROM_SIZE    = 40;
    localparam int DATA_WIDTH  = 10;
    localparam int DELAY_SHIFT = 2;
    localparam int AW          = $clog2(ROM_SIZE);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         rom_address;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  rom_address_overflow;
    logic [7:0]            tx_data;
    logic                  tx_dc;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  done;
    logic                  error;

    logic [9:0] rom_mem [0:ROM_SIZE-1];

    int checks_total  = 0;
    int checks_passed = 0;

    // Model results
    logic [8:0] exp_q[$];
    int         exp_cycles;
    logic       exp_err;

    always #5 clk = ~clk;

    assign rom_address_overflow = (int'(rom_address) >= ROM_SIZE);
    assign rom_data = rom_address_overflow ? 10'h3FF : rom_mem[rom_address];

    ssd1306_microcode_sequencer #(
        .ROM_SIZE    (ROM_SIZE),
        .DATA_WIDTH  (DATA_WIDTH),
        .DELAY_SHIFT (DELAY_SHIFT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .rom_address          (rom_address),
        .rom_data             (rom_data),
        .rom_address_overflow (rom_address_overflow),
        .tx_data              (tx_data),
        .tx_dc                (tx_dc),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < ROM_SIZE; i++) rom_mem[i] = 10'h3FF;
    endtask

    // Walks the ROM by the word rules: CMD/DATA cost 2 cycles and emit a byte,
    // DELAY costs 2 + payload*2^shift, END costs its fetch, and running off
    // the ROM costs one fetch and raises error. Stall cycles are added later.
    task automatic build_model();
        logic [1:0] op;
        logic [7:0] pl;
        exp_q.delete();
        exp_cycles = 0;
        exp_err    = 1'b0;
        for (int a = 0; a <= ROM_SIZE; a++) begin
            if (a == ROM_SIZE) begin
                exp_cycles += 1;
                exp_err = 1'b1;
                break;
            end
            op = rom_mem[a][9:8];
            pl = rom_mem[a][7:0];
            if (op == 2'd3) begin
                exp_cycles += 1;
                break;
            end else if (op == 2'd2) begin
                exp_cycles += 2 + (int'(pl) << DELAY_SHIFT);
            end else begin
                exp_q.push_back({op[0], pl});
                exp_cycles += 2;
            end
        end
    endtask

    task automatic check_reset_outputs(input string prefix);
        check({prefix, "_rom_address"}, 32'(rom_address), 32'd0);
        check({prefix, "_tx_data"},     32'(tx_data),     32'd0);
        check({prefix, "_tx_dc"},       32'(tx_dc),       32'd0);
        check({prefix, "_tx_valid"},    32'(tx_valid),    32'd0);
        check({prefix, "_busy"},        32'(busy),        32'd0);
        check({prefix, "_done"},        32'(done),        32'd0);
        check({prefix, "_error"},       32'(error),       32'd0);
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = first 5 offered cycles stalled.
    // inject: extra start pulses while busy and in the DONE cycle.
    task automatic run_seq(input string name, input int ready_mode, input bit inject,
                           input int budget, output int stall_count);
        int   k, done_k, done_pulses, stalls, recv, busy_late;
        logic err_at_done;
        build_model();
        k = 0; done_k = 0; done_pulses = 0; stalls = 0; recv = 0; busy_late = 0;
        err_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        tx_ready = 1'b1;
        while (k < budget) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (k == 1) begin
                check({name, "_busy_after_start"}, 32'(busy), 32'd1);
                check({name, "_error_cleared"},    32'(error), 32'd0);
            end
            if (done) begin
                done_pulses++;
                if (done_k == 0) begin
                    done_k = k;
                    err_at_done = error;
                end
            end
            if (done_k != 0 && k > done_k && busy) busy_late++;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (stalls >= 5);
            endcase
            if (tx_valid) begin
                if (recv < exp_q.size())
                    check({name, "_byte"}, 32'({tx_dc, tx_data}), 32'(exp_q[recv]));
                else
                    check({name, "_extra_byte"}, 32'(recv), 32'(exp_q.size()));
                if (tx_ready) recv++;
                else stalls++;
            end
            if (inject && (k == 3 || (done_k != 0 && k == done_k))) start = 1'b1;
            if (done_k != 0 && k >= done_k + 6) break;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        check({name, "_done_pulses"}, 32'(done_pulses), 32'd1);
        check({name, "_done_cycle"},  32'(done_k),      32'(1 + exp_cycles + stalls));
        check({name, "_byte_count"},  32'(recv),        32'(exp_q.size()));
        check({name, "_error"},       32'(err_at_done), 32'(exp_err));
        check({name, "_busy_late"},   32'(busy_late),   32'd0);
        stall_count = stalls;
    endtask

    initial begin
        int stalls;
        rst = 1'b1;
        start = 1'b0;
        tx_ready = 1'b0;
        clear_rom();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic CMD/CMD/DATA/END run: done expected 8 cycles after start
        rom_mem[0] = 10'h0AE; rom_mem[1] = 10'h0D5; rom_mem[2] = 10'h180; rom_mem[3] = 10'h3FF;
        run_seq("basic", 0, 1'b0, 100, stalls);

        // Five stalled cycles on the first byte
        run_seq("stall", 2, 1'b0, 100, stalls);
        check("stall_count", 32'(stalls), 32'd5);

        // DELAY payload 3 and payload 0
        clear_rom();
        rom_mem[0] = 10'h203;
        run_seq("delay3", 0, 1'b0, 100, stalls);
        rom_mem[0] = 10'h200;
        run_seq("delay0", 0, 1'b0, 100, stalls);

        // 40 CMD words, no END: overflow at address 40
        for (int i = 0; i < ROM_SIZE; i++) rom_mem[i] = {2'b00, 8'($urandom)};
        run_seq("overflow", 0, 1'b0, 400, stalls);
        check("overflow_address", 32'(rom_address), 32'(ROM_SIZE));
        check("overflow_error_sticky", 32'(error), 32'd1);
        run_seq("overflow_rerun", 1, 1'b0, 600, stalls);

        // Reset in SEND with tx_ready low, then replay from address 0
        clear_rom();
        rom_mem[0] = 10'h0AE; rom_mem[1] = 10'h0D5; rom_mem[2] = 10'h180;
        tx_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
        check("pre_rst_tx_data",  32'(tx_data),  32'hAE);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk) rst = 1'b0;
        run_seq("replay", 0, 1'b0, 100, stalls);

        // start pulses while busy and in the DONE cycle are ignored
        run_seq("inject", 0, 1'b1, 100, stalls);

        // Randomized programs with random tx_ready
        for (int iter = 0; iter < 4; iter++) begin
            int len;
            logic [1:0] op;
            clear_rom();
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                op = 2'($urandom_range(0, 2));
                rom_mem[i] = (op == 2'd2) ? {op, 8'($urandom_range(0, 3))} : {op, 8'($urandom)};
            end
            run_seq($sformatf("random%0d", iter), 1, 1'b0, 400, stalls);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
